// File: rtl/lu_pkg.sv
// rtl/lu_pkg.sv - shared types and constants for the logic-unit scheduler
// Contents:
//   LU_W     default operand/result width of lud
//   OP_*     lud opcode encoding (3 bits, all eight codes legal)
//   state_t  scheduler FSM states
package lu_pkg;

    localparam int LU_W = 32;

    localparam logic [2:0] OP_AND  = 3'b000;  // a & b
    localparam logic [2:0] OP_OR   = 3'b001;  // a | b
    localparam logic [2:0] OP_XOR  = 3'b010;  // a ^ b
    localparam logic [2:0] OP_NAND = 3'b011;  // ~(a & b)
    localparam logic [2:0] OP_NOR  = 3'b100;  // ~(a | b)
    localparam logic [2:0] OP_XNOR = 3'b101;  // ~(a ^ b)
    localparam logic [2:0] OP_ANDN = 3'b110;  // a & ~b
    localparam logic [2:0] OP_NOTA = 3'b111;  // ~a

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/lud.sv
// rtl/lud.sv - combinational bitwise logic unit
// Ports:
//   opt  in   3  opcode (see lu_pkg OP_*)
//   a    in   W  operand a
//   b    in   W  operand b
//   ans  out  W  result
module lud
    import lu_pkg::*;
#(
    parameter int W = LU_W
) (
    input  logic [2:0]   opt,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] ans
);

    always_comb begin
        ans = '0;
        case (opt)
            OP_AND:  ans = a & b;
            OP_OR:   ans = a | b;
            OP_XOR:  ans = a ^ b;
            OP_NAND: ans = ~(a & b);
            OP_NOR:  ans = ~(a | b);
            OP_XNOR: ans = ~(a ^ b);
            OP_ANDN: ans = a & ~b;
            OP_NOTA: ans = ~a;
            default: ans = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin priority picker
// Ports:
//   req  in   NREQ  request vector
//   ptr  in   IDW   highest-priority index this cycle
//   gnt  out  NREQ  one-hot grant (all zero when no request)
//   idx  out  IDW   encoded grant index (0 when no request)
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    int j;

    // Walk the rotated order from the far end back toward ptr so the
    // candidate closest to ptr is the last one written and wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        j   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/lu_rr_sched.sv
// rtl/lu_rr_sched.sv - round-robin scheduler sharing one lud among NREQ requesters
// Ports:
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   req_valid  in   NREQ    per-requester request valid
//   req_ready  out  NREQ    per-requester accept, at most one bit high
//   req_opt    in   3*NREQ  opcodes, requester i at [3i+2:3i]
//   req_a      in   W*NREQ  operand a, requester i at [Wi+W-1:Wi]
//   req_b      in   W*NREQ  operand b, same packing
//   rsp_valid  out  1       result valid
//   rsp_ready  in   1       downstream accepts result
//   rsp_id     out  IDW     requester owning rsp_data
//   rsp_data   out  W       lud result
//   busy       out  1       high in EXEC or HOLD
//   done_cnt   out  CNTW    results accepted downstream (wraps)
module lu_rr_sched
    import lu_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int W    = LU_W,
    parameter  int CNTW = 16,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [3*NREQ-1:0] req_opt,
    input  logic [W*NREQ-1:0] req_a,
    input  logic [W*NREQ-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_data,
    output logic              busy,
    output logic [CNTW-1:0]   done_cnt
);

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id_reg;
    logic [2:0]     op_reg;
    logic [W-1:0]   a_reg, b_reg;
    logic [W-1:0]   ans;

    logic [IDW-1:0]  next_ptr;
    logic [IDW-1:0]  arb_ptr;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            accept;
    logic            grant_any;
    logic            complete;

    assign next_ptr = (id_reg == IDW'(NREQ - 1)) ? '0 : id_reg + IDW'(1);

    // While a result is being retired in HOLD, ptr has not yet moved past
    // the requester being completed; arbitrate from where it is about to go
    // so the requester just served gets lowest priority.
    assign arb_ptr = (state == HOLD) ? next_ptr : ptr;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req_valid),
        .ptr (arb_ptr),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    // Gating with rst_n keeps req_ready low while reset is asserted.
    assign accept    = rst_n && ((state == IDLE) || ((state == HOLD) && rsp_ready));
    assign grant_any = accept && (|req_valid);
    assign req_ready = grant_any ? gnt : '0;
    assign complete  = (state == HOLD) && rsp_ready;
    assign busy      = (state != IDLE);

    lud #(.W(W)) u_lud (
        .opt (op_reg),
        .a   (a_reg),
        .b   (b_reg),
        .ans (ans)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = EXEC;
            EXEC:    state_nxt = HOLD;
            HOLD:    if (rsp_ready) state_nxt = grant_any ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            id_reg    <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            done_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (grant_any) begin
                id_reg <= gnt_idx;
                op_reg <= req_opt[int'(gnt_idx)*3 +: 3];
                a_reg  <= req_a[int'(gnt_idx)*W +: W];
                b_reg  <= req_b[int'(gnt_idx)*W +: W];
            end
            if (state == EXEC) begin
                rsp_data  <= ans;
                rsp_id    <= id_reg;
                rsp_valid <= 1'b1;
            end
            if (complete) begin
                done_cnt  <= done_cnt + CNTW'(1);
                ptr       <= next_ptr;
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lu_rr_sched.sv
// tb/tb_lu_rr_sched.sv - self-checking bench for lu_rr_sched
module tb_lu_rr_sched;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int CNTW = 4;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [3*NREQ-1:0] req_opt;
    logic [W*NREQ-1:0] req_a;
    logic [W*NREQ-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_data;
    logic              busy;
    logic [CNTW-1:0]   done_cnt;

    int vectors = 0;
    int errors  = 0;

    lu_rr_sched #(.NREQ(NREQ), .W(W), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_opt   (req_opt),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lud_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return ~(a ^ b);
            3'd6: return a & ~b;
            default: return ~a;
        endcase
    endfunction

    task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]     = 1'b1;
        req_opt[3*i +: 3] = op;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Drives one request from requester i and returns the response it produces.
    task automatic serve(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int id, output logic [31:0] d, output bit timeout);
        timeout = 1'b1;
        id = -1;
        d = '0;
        rsp_ready = 1'b1;
        set_req(i, op, a, b);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                @(posedge clk); #1;
                req_valid[i] = 1'b0;
                break;
            end
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                id = int'(rsp_id);
                d = rsp_data;
                timeout = 1'b0;
                @(posedge clk); #1;
                break;
            end
        end
        req_valid[i] = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        vectors++;
        if ({rsp_valid, req_ready, busy, done_cnt, rsp_id, rsp_data} !== '0)
            begin errors++; $display("FAIL reset_state got v=%0b rdy=%b busy=%0b cnt=%0d id=%0d data=%h exp all zero",
                rsp_valid, req_ready, busy, done_cnt, rsp_id, rsp_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        set_req(2, 3'b000, 32'h411C0000, 32'h3F100000);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got %b exp 0100", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        vectors++;
        if ({req_ready, rsp_valid, busy} !== 6'b000001)
            begin errors++; $display("FAIL single_exec got rdy=%b v=%0b busy=%0b exp 0000/0/1", req_ready, rsp_valid, busy); end
        @(negedge clk);
        vectors++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd2, 32'h01100000})
            begin errors++; $display("FAIL single_rsp got v=%0b id=%0d data=%h exp 1/2/01100000", rsp_valid, rsp_id, rsp_data); end
        @(negedge clk);
        vectors++;
        if ({done_cnt, rsp_valid, busy} !== {4'd1, 1'b0, 1'b0})
            begin errors++; $display("FAIL single_done got cnt=%0d v=%0b busy=%0b exp 1/0/0", done_cnt, rsp_valid, busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_opcodes();
        int id;
        logic [31:0] d, a, b;
        bit to;
        for (int op = 0; op < 8; op++) begin
            a = (op == 1 || op == 2) ? 32'h411C0000 : $urandom;
            b = (op == 1 || op == 2) ? 32'h3F100000 : $urandom;
            serve(0, 3'(op), a, b, id, d, to);
            vectors++;
            if (to || id != 0 || d !== lud_ref(3'(op), a, b))
                begin errors++; $display("FAIL opcode_%0d got to=%0b id=%0d data=%h exp id=0 data=%h", op, to, id, d, lud_ref(3'(op), a, b)); end
        end
        vectors++;
        if (lud_ref(3'd1, 32'h411C0000, 32'h3F100000) !== 32'h7F1C0000 || done_cnt !== 4'd9)
            begin errors++; $display("FAIL opcode_count got cnt=%0d exp 9", done_cnt); end
    endtask

    task automatic test_backpressure();
        logic [1:0]  cid;
        logic [31:0] cdata;
        bit seen;
        rsp_ready = 1'b0;
        set_req(1, 3'b010, 32'hA5A5_0F0F, 32'h0FF0_1234);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready[1]) break;
        end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        set_req(3, 3'b001, 32'h0000_00F0, 32'h0000_000F);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1'b1; break; end
        end
        cid = rsp_id;
        cdata = rsp_data;
        vectors++;
        if (!seen || cid !== 2'd1 || cdata !== (32'hA5A5_0F0F ^ 32'h0FF0_1234))
            begin errors++; $display("FAIL bp_first got seen=%0b id=%0d data=%h exp 1/%h", seen, cid, cdata, 32'hA5A5_0F0F ^ 32'h0FF0_1234); end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            vectors++;
            if ({rsp_valid, rsp_id, rsp_data, req_ready} !== {1'b1, cid, cdata, 4'b0000})
                begin errors++; $display("FAIL bp_hold_%0d got v=%0b id=%0d data=%h rdy=%b exp stable, rdy 0000", k, rsp_valid, rsp_id, rsp_data, req_ready); end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_release_grant got %b exp 1000", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        vectors++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd3, 32'h0000_00FF})
            begin errors++; $display("FAIL bp_second got v=%0b id=%0d data=%h exp 1/3/000000ff", rsp_valid, rsp_id, rsp_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        set_req(0, 3'b000, 32'hFFFF_0000, 32'h00FF_FF00);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready[0]) begin @(posedge clk); #1; req_valid[0] = 1'b0; break; end
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        for (int i = 0; i < NREQ; i++) set_req(i, 3'(i), 32'(i), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({rsp_valid, req_ready, busy, done_cnt} !== '0)
            begin errors++; $display("FAIL reset_mid got v=%0b rdy=%b busy=%0b cnt=%0d exp all zero", rsp_valid, req_ready, busy, done_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b exp 0001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) begin @(posedge clk); #1; break; end
        end
    endtask

    task automatic test_fairness();
        int gl[$];
        int gc[$];
        int rl[$];
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 3'(i), 32'h1111_1111 * (i + 1), 32'h0F0F_0F0F);
        for (int cyc = 0; cyc < 40 && rl.size() < 6; cyc++) begin
            @(negedge clk);
            if (rsp_valid) rl.push_back(int'(rsp_id));
            if (req_ready != '0) begin
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) gl.push_back(i);
                gc.push_back(cyc);
            end
            @(posedge clk); #1;
            if (gl.size() >= 6) req_valid = '0;
        end
        vectors++;
        if (gl.size() != 6 || rl.size() != 6)
            begin errors++; $display("FAIL fair_counts got grants=%0d results=%0d exp 6/6", gl.size(), rl.size()); end
        else begin
            for (int k = 0; k < 6; k++) begin
                vectors++;
                if (gl[k] != k % NREQ || rl[k] != k % NREQ)
                    begin errors++; $display("FAIL fair_order_%0d got grant=%0d result=%0d exp %0d", k, gl[k], rl[k], k % NREQ); end
                if (k > 0) begin
                    vectors++;
                    if (gc[k] - gc[k-1] != 2)
                        begin errors++; $display("FAIL fair_spacing_%0d got %0d exp 2", k, gc[k] - gc[k-1]); end
                end
            end
        end
        @(negedge clk);
        vectors++;
        if (done_cnt !== 4'd6) begin errors++; $display("FAIL fair_done got %0d exp 6", done_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        int id;
        int bad;
        logic [31:0] d;
        bit to;
        bit seen;
        do_reset();
        bad = 0;
        for (int k = 0; k < 17; k++) begin
            serve((k + 2) % NREQ, 3'b010, 32'(k), 32'hFFFF_FFFF, id, d, to);
            if (to || id != (k + 2) % NREQ || d !== ~32'(k)) bad++;
        end
        @(negedge clk);
        vectors++;
        if (bad != 0 || done_cnt !== 4'd1)
            begin errors++; $display("FAIL wrap_count got cnt=%0d badrsp=%0d exp 1/0", done_cnt, bad); end
        @(posedge clk); #1;
        set_req(1, 3'b000, 32'h1, 32'h1);
        set_req(3, 3'b000, 32'h3, 32'h3);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_first got %b exp 1000", req_ready); end
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin seen = 1'b1; break; end
        end
        vectors++;
        if (!seen || req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_second got %b exp 0010", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) begin @(posedge clk); #1; break; end
        end
    endtask

    // Reference: a request is outstanding for one cycle (result computing)
    // and then offered until taken; priority starts just after the last
    // requester granted.
    task automatic test_random();
        int phase;
        int last_g;
        int g;
        int unsigned mcount;
        int exp_id;
        logic [31:0] exp_data;
        logic [NREQ-1:0] exp_ready, granted;
        do_reset();
        phase = 0; last_g = NREQ - 1; mcount = 0; exp_id = 0; exp_data = '0; granted = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && granted[i]) begin
                    req_valid[i] = 1'b0;
                    if ($urandom % 2 == 0) set_req(i, 3'($urandom), $urandom, $urandom);
                end else if (!req_valid[i]) begin
                    if ($urandom % 3 == 0) set_req(i, 3'($urandom), $urandom, $urandom);
                end else if ($urandom % 16 == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom % 3) != 0;
            @(negedge clk);
            g = -1;
            if (phase == 0 || (phase == 2 && rsp_ready))
                for (int k = 0; k < NREQ; k++)
                    if (g < 0 && req_valid[(last_g + 1 + k) % NREQ]) g = (last_g + 1 + k) % NREQ;
            exp_ready = (g >= 0) ? NREQ'(1) << g : '0;
            vectors++;
            if (req_ready !== exp_ready) begin errors++; $display("FAIL rand_ready cyc=%0d got %b exp %b", cyc, req_ready, exp_ready); end
            vectors++;
            if (rsp_valid !== (phase == 2) || busy !== (phase != 0) || done_cnt !== CNTW'(mcount))
                begin errors++; $display("FAIL rand_status cyc=%0d got v=%0b busy=%0b cnt=%0d exp %0b/%0b/%0d",
                    cyc, rsp_valid, busy, done_cnt, phase == 2, phase != 0, CNTW'(mcount)); end
            if (phase == 2) begin
                vectors++;
                if (int'(rsp_id) != exp_id || rsp_data !== exp_data)
                    begin errors++; $display("FAIL rand_rsp cyc=%0d got id=%0d data=%h exp %0d/%h", cyc, rsp_id, rsp_data, exp_id, exp_data); end
            end
            if (phase == 2 && rsp_ready) begin mcount++; phase = 0; end
            else if (phase == 1) phase = 2;
            if (g >= 0) begin
                exp_id = g;
                exp_data = lud_ref(req_opt[3*g +: 3], req_a[32*g +: 32], req_b[32*g +: 32]);
                last_g = g;
                phase = 1;
            end
            granted = exp_ready;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_opt = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_opcodes();
        test_backpressure();
        test_reset_mid();
        test_fairness();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
